wb_spi_flash_reader: RTL and testbench

Read-only Wishbone slave on the interconnect's SPI-flash port. Every Wishbone read becomes one SPI READ (0x03) transaction to an external serial NOR flash, returning one 32-bit little-endian word. Boot-ROM code uses it to copy the program image from flash into instruction memory. Writes are rejected with a bus error.

---
 rtl/spi_flash_pkg.sv | 22 ++
 rtl/spi_sck_gen.sv | 52 +++++
 rtl/wb_spi_flash_reader.sv | 176 +++++++++++++++++
 tb/tb_wb_spi_flash_reader.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_flash_pkg.sv
// Shared types and constants for the Wishbone SPI flash reader.
package spi_flash_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4,
    GAP   = 3'd5
  } state_t;

  localparam logic [7:0] SPI_READ_CMD = 8'h03;
  localparam int         FRAME_BITS   = 64;
  localparam int         ADDR_BITS    = 24;

  // Flash bytes arrive b0 first; the bus wants them little-endian.
  function automatic logic [31:0] bytes_to_word(input logic [31:0] rx);
    return {rx[7:0], rx[15:8], rx[23:16], rx[31:24]};
  endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// SCK divider: mode-0 clock with single-cycle rise/fall strobes, held low when disabled.
module spi_sck_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic sck_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int               CNT_W    = $clog2(CLK_DIV) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sck_q, sck_d;
  logic             tick_s;

  assign tick_s = en_i & (cnt_q == CNT_LAST);
  assign rise_o = tick_s & ~sck_q;
  assign fall_o = tick_s & sck_q;
  assign sck_o  = sck_q;

  // Count half-periods and toggle SCK at each terminal count; park low when disabled.
  always_comb begin
    cnt_d = cnt_q;
    sck_d = sck_q;
    if (!en_i) begin
      cnt_d = '0;
      sck_d = 1'b0;
    end else if (tick_s) begin
      cnt_d = '0;
      sck_d = ~sck_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
      sck_d = sck_q;
    end
  end

  // Divider state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sck_q <= sck_d;
    end
  end

endmodule

// File: rtl/wb_spi_flash_reader.sv
// Read-only Wishbone slave: each read issues one SPI READ (0x03) frame and
// returns a 32-bit little-endian word; writes terminate with a bus error.
module wb_spi_flash_reader #(
  parameter int CLK_DIV   = 2,
  parameter int ADDR_BITS = 24
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        sck_o,
  output logic        ss_o,
  output logic        mosi_o,
  input  logic        miso_i
);

  import spi_flash_pkg::*;

  localparam logic [5:0] LAST_BIT = 6'(FRAME_BITS - 1);

  state_t      state_q, state_d;
  logic        ss_q, ss_d;
  logic        mosi_q, mosi_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic        last_q, last_d;
  logic [31:0] dat_q, dat_d;
  logic [31:0] tx_q, tx_d;
  logic [31:0] rx_q, rx_d;
  logic [5:0]  bit_q, bit_d;

  logic [31:0] frame_s;
  logic        req_s;
  logic        gen_en_s;
  logic        sck_s, rise_s, fall_s;
  logic        unused_s;

  assign req_s    = wb_cyc_i & wb_stb_i;
  assign frame_s  = {SPI_READ_CMD, wb_adr_i[ADDR_BITS-1:2], 2'b00};
  assign unused_s = ^{wb_dat_i, wb_sel_i, wb_adr_i[31:ADDR_BITS], wb_adr_i[1:0]};

  // SCK runs through SETUP and SHIFT; it stops for the final low cycle and on abort.
  assign gen_en_s = wb_cyc_i & ((state_q == SETUP) | ((state_q == SHIFT) & ~last_q));

  spi_sck_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sck_gen (
    .clk_i  (wb_clk_i),
    .rst_i  (wb_rst_i),
    .en_i   (gen_en_s),
    .sck_o  (sck_s),
    .rise_o (rise_s),
    .fall_o (fall_s)
  );

  assign sck_o    = sck_s;
  assign ss_o     = ss_q;
  assign mosi_o   = mosi_q;
  assign wb_ack_o = ack_q;
  assign wb_err_o = err_q;
  assign wb_dat_o = dat_q;

  // Next-state and next-output logic of the transaction FSM.
  always_comb begin
    state_d = state_q;
    ss_d    = ss_q;
    mosi_d  = mosi_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    last_d  = last_q;
    dat_d   = dat_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    bit_d   = bit_q;
    case (state_q)
      IDLE: begin
        if (req_s && wb_we_i) begin
          state_d = ERR;
          err_d   = 1'b1;
        end else if (req_s) begin
          state_d = SETUP;
          ss_d    = 1'b0;
          tx_d    = frame_s;
          mosi_d  = frame_s[31];
          rx_d    = '0;
          bit_d   = '0;
          last_d  = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      SETUP, SHIFT: begin
        if (!wb_cyc_i) begin
          // Master gave up: release the flash silently.
          state_d = IDLE;
          ss_d    = 1'b1;
          mosi_d  = 1'b0;
          last_d  = 1'b0;
        end else if (last_q) begin
          state_d = DONE;
          ss_d    = 1'b1;
          mosi_d  = 1'b0;
          ack_d   = 1'b1;
          dat_d   = bytes_to_word(rx_q);
          last_d  = 1'b0;
        end else begin
          state_d = SHIFT;
          if (rise_s) begin
            rx_d = {rx_q[30:0], miso_i};
          end else begin
            rx_d = rx_q;
          end
          // Outgoing bits advance after each falling edge; zeros follow the address.
          if (fall_s) begin
            mosi_d = tx_q[30];
            tx_d   = {tx_q[30:0], 1'b0};
            bit_d  = bit_q + 6'd1;
            last_d = (bit_q == LAST_BIT);
          end else begin
            mosi_d = mosi_q;
          end
        end
      end
      DONE: begin
        state_d = GAP;
      end
      ERR: begin
        state_d = GAP;
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        ss_d    = 1'b1;
        mosi_d  = 1'b0;
        last_d  = 1'b0;
      end
    endcase
  end

  // FSM state and registered bus/SPI outputs.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      ss_q    <= 1'b1;
      mosi_q  <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      last_q  <= 1'b0;
      dat_q   <= 32'h0000_0000;
      tx_q    <= 32'h0000_0000;
      rx_q    <= 32'h0000_0000;
      bit_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      ss_q    <= ss_d;
      mosi_q  <= mosi_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      last_q  <= last_d;
      dat_q   <= dat_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      bit_q   <= bit_d;
    end
  end

endmodule

// File: tb/tb_wb_spi_flash_reader.sv
// Bench for wb_spi_flash_reader: behavioural SPI flash plus directed and random reads.
module tb_wb_spi_flash_reader;

  localparam int CLK_DIV = 2;
  localparam int ACK_LAT = 2 + 128 * CLK_DIV;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        wb_cyc_i = 1'b0;
  logic        wb_stb_i = 1'b0;
  logic [31:0] wb_adr_i = 32'h0;
  logic [31:0] wb_dat_i = 32'h0;
  logic [3:0]  wb_sel_i = 4'h0;
  logic        wb_we_i  = 1'b0;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o, wb_err_o, sck_o, ss_o, mosi_o;
  logic        miso_i = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  // Flash model state
  logic [31:0] f_cmd = 32'h0;
  int          f_rises = 0;
  bit          f_active = 1'b0;
  int          stray_sck = 0;
  logic        prev_ss = 1'b1;
  logic        prev_sck = 1'b0;
  logic [7:0]  f_byte;
  logic [31:0] cmd_q[$];
  int          rises_q[$];

  int ss_hi_run = 0;
  int last_gap = 0;

  wb_spi_flash_reader #(.CLK_DIV(CLK_DIV), .ADDR_BITS(24)) dut (
    .wb_clk_i (wb_clk_i), .wb_rst_i (wb_rst_i), .wb_cyc_i (wb_cyc_i),
    .wb_stb_i (wb_stb_i), .wb_adr_i (wb_adr_i), .wb_dat_i (wb_dat_i),
    .wb_sel_i (wb_sel_i), .wb_we_i  (wb_we_i),  .wb_dat_o (wb_dat_o),
    .wb_ack_o (wb_ack_o), .wb_err_o (wb_err_o), .sck_o    (sck_o),
    .ss_o     (ss_o),     .mosi_o   (mosi_o),   .miso_i   (miso_i)
  );

  initial forever #5 wb_clk_i = ~wb_clk_i;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    case (a)
      24'h000104: return 8'h11;
      24'h000105: return 8'h22;
      24'h000106: return 8'h33;
      24'h000107: return 8'h44;
      default:    return (a[7:0] * 8'd7) ^ a[15:8] ^ a[23:16] ^ 8'h3C;
    endcase
  endfunction

  function automatic logic [31:0] flash_word(input logic [23:0] a);
    return {flash_byte(a + 24'd3), flash_byte(a + 24'd2), flash_byte(a + 24'd1), flash_byte(a)};
  endfunction

  // SPI flash slave, mode 0: sample MOSI on SCK rise, drive MISO after SCK fall.
  initial forever begin
    @(ss_o or sck_o);
    if (prev_ss === 1'b1 && ss_o === 1'b0) begin
      f_active = 1'b1;
      f_rises  = 0;
      f_cmd    = 32'h0;
    end
    if (prev_sck !== 1'b1 && sck_o === 1'b1) begin
      if (f_active) begin
        if (f_rises < 32) f_cmd = {f_cmd[30:0], mosi_o};
        f_rises++;
      end else begin
        stray_sck++;
      end
    end
    if (prev_sck === 1'b1 && sck_o === 1'b0) begin
      if (f_active && f_rises >= 32 && f_rises < 64) begin
        f_byte = flash_byte(f_cmd[23:0] + 24'((f_rises - 32) / 8));
        miso_i = f_byte[7 - ((f_rises - 32) % 8)];
      end else begin
        miso_i = 1'b0;
      end
    end
    if (prev_ss === 1'b0 && ss_o === 1'b1 && f_active) begin
      cmd_q.push_back(f_cmd);
      rises_q.push_back(f_rises);
      f_active = 1'b0;
    end
    prev_ss  = ss_o;
    prev_sck = sck_o;
  end

  // Track how long chip select stays high before each frame.
  initial forever begin
    @(negedge wb_clk_i);
    if (ss_o === 1'b1) begin
      ss_hi_run++;
    end else begin
      if (ss_hi_run > 0) last_gap = ss_hi_run;
      ss_hi_run = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
  endtask

  // Issue a read at a negedge; extra = cycles the request sits unsampled in GAP.
  // Returns at the negedge after the ack with the request still driven.
  task automatic do_read(input logic [31:0] adr, input int extra, input string tag);
    logic [23:0] fa;
    logic [31:0] exp_d;
    int n;
    bit got;
    int nfr;
    fa    = {adr[23:2], 2'b00};
    exp_d = flash_word(fa);
    nfr   = cmd_q.size();
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = adr;
    wb_dat_i = $urandom; wb_sel_i = 4'($urandom);
    @(posedge wb_clk_i);
    n = 0; got = 1'b0;
    while (!got && n < ACK_LAT + extra + 20) begin
      @(negedge wb_clk_i);
      n++;
      if (n == 1 + extra)       chk({tag, "_ss_low"}, 32'(ss_o), 32'd0);
      if (n == CLK_DIV + extra) chk({tag, "_sck_pre"}, 32'(sck_o), 32'd0);
      if (n == 1 + CLK_DIV + extra) chk({tag, "_sck_rise1"}, 32'(sck_o), 32'd1);
      if (wb_ack_o === 1'b1) got = 1'b1;
    end
    chk({tag, "_ack_lat"}, 32'(n), 32'(ACK_LAT + extra));
    chk({tag, "_data"}, wb_dat_o, exp_d);
    chk({tag, "_ss_done"}, 32'(ss_o), 32'd1);
    chk({tag, "_sck_done"}, 32'(sck_o), 32'd0);
    chk({tag, "_err"}, 32'(wb_err_o), 32'd0);
    @(negedge wb_clk_i);
    chk({tag, "_ack_1cyc"}, 32'(wb_ack_o), 32'd0);
    chk({tag, "_frames"}, 32'(cmd_q.size()), 32'(nfr + 1));
    if (cmd_q.size() > 0) begin
      chk({tag, "_cmd"}, cmd_q[$], {8'h03, fa});
      chk({tag, "_rises"}, 32'(rises_q[$]), 32'd64);
    end
  endtask

  initial begin
    int nfr;
    int bad_cnt;
    int exp_r;
    logic [31:0] a;

    // Reset state
    repeat (3) @(negedge wb_clk_i);
    chk("rst_dat", wb_dat_o, 32'h0);
    chk("rst_ack", 32'(wb_ack_o), 32'd0);
    chk("rst_err", 32'(wb_err_o), 32'd0);
    chk("rst_sck", 32'(sck_o), 32'd0);
    chk("rst_ss", 32'(ss_o), 32'd1);
    chk("rst_mosi", 32'(mosi_o), 32'd0);
    wb_rst_i = 1'b0;
    repeat (2) @(negedge wb_clk_i);

    // Known-data read
    do_read(32'h0000_0104, 0, "rd104");
    idle();
    repeat (3) @(negedge wb_clk_i);
    chk("rd104_hold_data", wb_dat_o, 32'h4433_2211);
    chk("rd104_cmd_const", cmd_q[$], 32'h0300_0104);

    // Address aliasing
    do_read(32'hFF00_0012, 0, "alias");
    idle();
    chk("alias_cmd_const", cmd_q[$], 32'h0300_0010);
    repeat (2) @(negedge wb_clk_i);

    // Write is rejected
    nfr = cmd_q.size();
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = 32'h0; wb_dat_i = $urandom;
    @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    chk("wr_err", 32'(wb_err_o), 32'd1);
    chk("wr_ack", 32'(wb_ack_o), 32'd0);
    chk("wr_ss", 32'(ss_o), 32'd1);
    idle();
    @(negedge wb_clk_i);
    chk("wr_err_1cyc", 32'(wb_err_o), 32'd0);
    bad_cnt = 0;
    repeat (10) begin
      @(negedge wb_clk_i);
      if (ss_o !== 1'b1 || sck_o !== 1'b0 || wb_ack_o !== 1'b0 || wb_err_o !== 1'b0) bad_cnt++;
    end
    chk("wr_quiet", 32'(bad_cnt), 32'd0);
    chk("wr_frames", 32'(cmd_q.size()), 32'(nfr));

    // Lazy master holds the request through the cycle after ack
    do_read($urandom, 0, "lazy");
    @(negedge wb_clk_i);
    idle();
    nfr = cmd_q.size();
    bad_cnt = 0;
    repeat (20) begin
      @(negedge wb_clk_i);
      if (ss_o !== 1'b1 || wb_ack_o !== 1'b0) bad_cnt++;
    end
    chk("lazy_no_dup", 32'(bad_cnt), 32'd0);
    chk("lazy_frames", 32'(cmd_q.size()), 32'(nfr));

    // Back-to-back reads, second request already driven during GAP
    nfr = cmd_q.size();
    do_read($urandom, 0, "b2b1");
    do_read($urandom, 1, "b2b2");
    idle();
    chk("b2b_frames", 32'(cmd_q.size()), 32'(nfr + 2));
    chk("b2b_ss_gap", 32'(last_gap >= 2), 32'd1);
    repeat (2) @(negedge wb_clk_i);

    // Abort by dropping cyc at T+50
    nfr = cmd_q.size();
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = $urandom;
    @(posedge wb_clk_i);
    repeat (50) @(negedge wb_clk_i);
    idle();
    @(negedge wb_clk_i);
    chk("abort_ss", 32'(ss_o), 32'd1);
    chk("abort_sck", 32'(sck_o), 32'd0);
    bad_cnt = 0;
    repeat (300) begin
      @(negedge wb_clk_i);
      if (wb_ack_o !== 1'b0 || wb_err_o !== 1'b0 || ss_o !== 1'b1) bad_cnt++;
    end
    chk("abort_quiet", 32'(bad_cnt), 32'd0);
    chk("abort_frames", 32'(cmd_q.size()), 32'(nfr + 1));
    exp_r = (49 - CLK_DIV) / (2 * CLK_DIV) + 1;
    if (rises_q.size() > 0) chk("abort_rises", 32'(rises_q[$]), 32'(exp_r));
    do_read(32'h0000_0104, 0, "post_abort");
    idle();
    repeat (2) @(negedge wb_clk_i);

    // Random reads
    for (int i = 0; i < 6; i++) begin
      a = $urandom;
      do_read(a, 0, "rand");
      idle();
      repeat ($urandom_range(1, 4)) @(negedge wb_clk_i);
    end

    // Asynchronous reset mid-SHIFT
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = $urandom;
    @(posedge wb_clk_i);
    repeat (100) @(negedge wb_clk_i);
    #2 wb_rst_i = 1'b1;
    #1;
    chk("arst_dat", wb_dat_o, 32'h0);
    chk("arst_ack", 32'(wb_ack_o), 32'd0);
    chk("arst_err", 32'(wb_err_o), 32'd0);
    chk("arst_sck", 32'(sck_o), 32'd0);
    chk("arst_ss", 32'(ss_o), 32'd1);
    chk("arst_mosi", 32'(mosi_o), 32'd0);
    idle();
    repeat (2) @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    repeat (2) @(negedge wb_clk_i);
    do_read(32'h0000_0104, 0, "post_rst");
    idle();
    chk("post_rst_data_const", wb_dat_o, 32'h4433_2211);
    repeat (4) @(negedge wb_clk_i);

    chk("stray_sck", 32'(stray_sck), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
